// File: rtl/eth_frame_pkg.sv
// Shared framing constants and state encoding for the sync-word Ethernet-style
// framer/parser pair. The header is four 32-bit beats carrying sync, DA, SA and link type.
package eth_frame_pkg;

   typedef enum logic [2:0] {
      HDR0    = 3'd0,
      HDR1    = 3'd1,
      HDR2    = 3'd2,
      HDR3    = 3'd3,
      PAYLOAD = 3'd4,
      DROP    = 3'd5
   } state_t;

   localparam int          HDR_BEATS      = 4;
   localparam logic [47:0] BROADCAST_ADDR = 48'hFFFF_FFFF_FFFF;

   // Bit offsets within header beats: beat0 = {sync, DA[47:32]}, beat3 = {SA[15:0], LT}
   localparam int SYNC_LSB  = 16;
   localparam int SYNC_MSB  = 31;
   localparam int SA_LO_LSB = 16;
   localparam int LT_LSB    = 0;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer with a registered input ready; one cycle of
// latency and full throughput while the sink keeps ready high.
module axis_skid_buffer #(
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
);

   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] skid_data;
   logic             main_valid;
   logic             skid_valid;
   logic             skid_valid_nxt;
   logic             push;
   logic             main_free;

   assign push      = s_valid & s_ready;
   assign main_free = ~main_valid | m_ready;
   assign m_valid   = main_valid;
   assign m_data    = main_data;

   // Skid entry fills only when the output register is stalled
   always_comb begin
      skid_valid_nxt = skid_valid;
      if (main_free) begin
         skid_valid_nxt = 1'b0;
      end else if (push) begin
         skid_valid_nxt = 1'b1;
      end else begin
         skid_valid_nxt = skid_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         s_ready    <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
      end else begin
         s_ready    <= ~skid_valid_nxt;
         skid_valid <= skid_valid_nxt;
         if (main_free) begin
            if (skid_valid) begin
               main_data  <= skid_data;
               main_valid <= 1'b1;
            end else if (push) begin
               main_data  <= s_data;
               main_valid <= 1'b1;
            end else begin
               main_valid <= 1'b0;
            end
         end else if (push) begin
            skid_data <= s_data;
         end
      end
   end

endmodule

// File: rtl/eth_frame_parser.sv
// Receive-side frame parser: checks the sync word, captures DA/SA/link type,
// strips the header and forwards exactly Packet_Size payload beats; errors are counted.
module eth_frame_parser
   import eth_frame_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter bit FILTER_EN  = 1'b1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   input  logic [15:0]           SyncWord,
   input  logic [47:0]           Local_Address,
   input  logic [13:0]           Packet_Size,
   output logic [47:0]           Destination_Address,
   output logic [47:0]           Source_Address,
   output logic [15:0]           Link_Type,
   output logic                  Header_Valid,
   output logic [CNT_WIDTH-1:0]  Sync_Err_Count,
   output logic [CNT_WIDTH-1:0]  Len_Err_Count,
   output logic [CNT_WIDTH-1:0]  Filt_Count
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   state_t       state, state_nxt;
   logic         run;
   logic [13:0]  remaining;
   logic [15:0]  da_hi;
   logic [31:0]  da_lo;
   logic [31:0]  sa_hi;
   logic [47:0]  da_full;
   logic         s_hs, skid_in_ready, filt_miss;
   logic         push, push_last, hdr_ok, inc_sync, inc_len, inc_filt;

   assign s_hs          = s_axis_tvalid & s_axis_tready;
   // run holds ready low for the first cycle after reset
   assign s_axis_tready = (state == PAYLOAD) ? skid_in_ready : run;
   assign da_full       = {da_hi, da_lo};
   assign filt_miss     = FILTER_EN && (da_full != Local_Address) && (da_full != BROADCAST_ADDR);

   // Next-state and per-beat event decode
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      push_last = 1'b0;
      hdr_ok    = 1'b0;
      inc_sync  = 1'b0;
      inc_len   = 1'b0;
      inc_filt  = 1'b0;
      case (state)
         HDR0: begin
            if (s_hs) begin
               if (s_axis_tdata[SYNC_MSB:SYNC_LSB] != SyncWord) begin
                  inc_sync  = 1'b1;
                  state_nxt = s_axis_tlast ? HDR0 : DROP;
               end else if (s_axis_tlast) begin
                  inc_len   = 1'b1;
                  state_nxt = HDR0;
               end else begin
                  state_nxt = HDR1;
               end
            end else begin
               state_nxt = HDR0;
            end
         end
         HDR1, HDR2: begin
            if (s_hs) begin
               if (s_axis_tlast) begin
                  inc_len   = 1'b1;
                  state_nxt = HDR0;
               end else begin
                  state_nxt = (state == HDR1) ? HDR2 : HDR3;
               end
            end else begin
               state_nxt = state;
            end
         end
         HDR3: begin
            if (s_hs) begin
               if (s_axis_tlast && (remaining != 14'd0)) begin
                  inc_len   = 1'b1;
                  state_nxt = HDR0;
               end else if (!s_axis_tlast && (remaining == 14'd0)) begin
                  inc_len   = 1'b1;
                  state_nxt = DROP;
               end else if (filt_miss) begin
                  hdr_ok    = 1'b1;
                  inc_filt  = 1'b1;
                  state_nxt = s_axis_tlast ? HDR0 : DROP;
               end else begin
                  hdr_ok    = 1'b1;
                  state_nxt = s_axis_tlast ? HDR0 : PAYLOAD;
               end
            end else begin
               state_nxt = HDR3;
            end
         end
         PAYLOAD: begin
            if (s_hs) begin
               push      = 1'b1;
               push_last = (remaining == 14'd1) | s_axis_tlast;
               if (s_axis_tlast) begin
                  inc_len   = (remaining > 14'd1);
                  state_nxt = HDR0;
               end else if (remaining == 14'd1) begin
                  inc_len   = 1'b1;
                  state_nxt = DROP;
               end else begin
                  state_nxt = PAYLOAD;
               end
            end else begin
               state_nxt = PAYLOAD;
            end
         end
         DROP: begin
            if (s_hs && s_axis_tlast) begin
               state_nxt = HDR0;
            end else begin
               state_nxt = DROP;
            end
         end
         default: begin
            state_nxt = HDR0;
         end
      endcase
   end

   // State, header capture, published fields and status counters
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state               <= HDR0;
         run                 <= 1'b0;
         remaining           <= 14'd0;
         da_hi               <= 16'd0;
         da_lo               <= 32'd0;
         sa_hi               <= 32'd0;
         Destination_Address <= 48'd0;
         Source_Address      <= 48'd0;
         Link_Type           <= 16'd0;
         Header_Valid        <= 1'b0;
         Sync_Err_Count      <= '0;
         Len_Err_Count       <= '0;
         Filt_Count          <= '0;
      end else begin
         state        <= state_nxt;
         run          <= 1'b1;
         Header_Valid <= hdr_ok;
         if (s_hs && (state == HDR0)) begin
            remaining <= Packet_Size;
            da_hi     <= s_axis_tdata[15:0];
         end else if (push) begin
            remaining <= remaining - 14'd1;
         end
         if (s_hs && (state == HDR1)) da_lo <= s_axis_tdata;
         if (s_hs && (state == HDR2)) sa_hi <= s_axis_tdata;
         if (hdr_ok) begin
            Destination_Address <= da_full;
            Source_Address      <= {sa_hi, s_axis_tdata[SA_LO_LSB +: 16]};
            Link_Type           <= s_axis_tdata[LT_LSB +: 16];
         end
         if (inc_sync) Sync_Err_Count <= sat_inc(Sync_Err_Count);
         if (inc_len)  Len_Err_Count  <= sat_inc(Len_Err_Count);
         if (inc_filt) Filt_Count     <= sat_inc(Filt_Count);
      end
   end

   axis_skid_buffer #(.WIDTH(DATA_WIDTH + 1)) u_skid (
      .clk     (ACLK),
      .rst     (ARESET),
      .s_valid (push),
      .s_ready (skid_in_ready),
      .s_data  ({push_last, s_axis_tdata}),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready),
      .m_data  ({m_axis_tlast, m_axis_tdata})
   );

endmodule
